// File: rtl/pkg_switch.sv
// Shared definitions for the switch port datapath: packet word layout,
// packet classification and the receive FIFO entry format.
package pkg_switch;

  localparam int NUM_PORTS = 4;

  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 8;
  localparam int SRC_MSB  = 7;
  localparam int SRC_LSB  = 4;
  localparam int TGT_MSB  = 3;
  localparam int TGT_LSB  = 0;

  localparam int ENTRY_W = 22;

  typedef enum logic [1:0] {
    SINGLE    = 2'd0,
    MULTICAST = 2'd1,
    BROADCAST = 2'd2,
    INVALID   = 2'd3
  } pkt_type_e;

  typedef enum logic {
    OUT_EMPTY   = 1'b0,
    OUT_PRESENT = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dest;
    pkt_type_e   ptype;
  } fifo_entry_t;

  function automatic pkt_type_e classify(input logic [NUM_PORTS-1:0] target);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (target[i]) ones++;
    end
    if (ones == 0)              return INVALID;
    else if (ones == 1)         return SINGLE;
    else if (target == '1)      return BROADCAST;
    else                        return MULTICAST;
  endfunction

endpackage

// File: rtl/switch_rx_fifo.sv
// Synchronous FIFO with registered read port; the read register prefetches
// the next head so a freshly written or freshly exposed entry is visible one edge later.
module switch_rx_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_wr;
  logic             do_rd;

  assign full        = (count_reg == CW'(DEPTH));
  assign empty       = (count_reg == '0);
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign rd_ptr_next = do_rd ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  assign count       = count_reg;
  assign rd_data     = rd_data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Forward the write data when it lands on the slot becoming the new head.
  always_ff @(posedge clk) begin
    if (do_wr) mem_reg[wr_ptr_reg] <= wr_data;
    if (do_wr && (wr_ptr_reg == rd_ptr_next)) rd_data_reg <= wr_data;
    else                                      rd_data_reg <= mem_reg[rd_ptr_next];
  end

endmodule

// File: rtl/switch_port_rx.sv
// Ingress receiver for one switch port: validates, classifies and buffers packets,
// then offers them to the fabric. Define SWITCH_RX_STATS_EN to add the accepted-packet counter.
module switch_port_rx
  import pkg_switch::*;
#(
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ip_valid,
  input  logic [15:0]      ip_data,
  output logic             ip_suspend,
  output logic             fwd_valid,
  output logic [15:0]      fwd_data,
  output logic [3:0]       fwd_dest,
  output logic [1:0]       fwd_type,
  input  logic             fwd_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [15:0]      rx_pkt_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_PORTS-1:0] own_mask;
  logic [NUM_PORTS-1:0] src;
  logic [NUM_PORTS-1:0] tgt;
  logic [NUM_PORTS-1:0] dest;
  logic                 pkt_ok;
  logic                 accept;
  logic                 wr_en;
  logic                 drop_en;
  logic                 rd_en;
  fifo_entry_t          wr_entry;
  fifo_entry_t          head;
  logic [ENTRY_W-1:0]   head_bits;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  out_state_e           state_reg;
  out_state_e           state_next;
  logic [CNT_W-1:0]     drop_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_own
      assign own_mask[gi] = (gi == PORT_ID);
    end
  endgenerate

  assign src  = ip_data[SRC_MSB:SRC_LSB];
  assign tgt  = ip_data[TGT_MSB:TGT_LSB];
  assign dest = tgt & ~own_mask;

  // A nonzero dest already implies a nonzero target; both are kept for clarity.
  assign pkt_ok  = (tgt != '0) && (src == own_mask) && (dest != '0);
  assign accept  = ip_valid && !ip_suspend;
  assign wr_en   = accept && pkt_ok;
  assign drop_en = accept && !pkt_ok;

  assign wr_entry = '{data:  {ip_data[DATA_MSB:DATA_LSB], src, tgt},
                      dest:  dest,
                      ptype: classify(tgt)};

  switch_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head       = head_bits;
  assign ip_suspend = fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= OUT_EMPTY;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    fwd_valid  = 1'b0;
    fwd_data   = '0;
    fwd_dest   = '0;
    fwd_type   = SINGLE;
    case (state_reg)
      OUT_EMPTY: begin
        if (!fifo_empty) state_next = OUT_PRESENT;
      end
      OUT_PRESENT: begin
        fwd_valid = 1'b1;
        fwd_data  = head.data;
        fwd_dest  = head.dest;
        fwd_type  = head.ptype;
        if (fwd_ready) begin
          rd_en = 1'b1;
          // Something remains after this pop if another entry is queued or one arrives now.
          if (!((fifo_count > CW'(1)) || wr_en)) state_next = OUT_EMPTY;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                drop_cnt_reg <= '0;
    else if (drop_en && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
  end

  assign drop_cnt = drop_cnt_reg;

`ifdef SWITCH_RX_STATS_EN
  logic [15:0] rx_pkt_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    rx_pkt_cnt_reg <= '0;
    else if (wr_en && (rx_pkt_cnt_reg != 16'hFFFF)) rx_pkt_cnt_reg <= rx_pkt_cnt_reg + 16'd1;
  end

  assign rx_pkt_cnt = rx_pkt_cnt_reg;
`else
  assign rx_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_port_rx.sv
// Scoreboard bench for switch_port_rx (PORT_ID=1): the driver queues expected
// packets from a reference model, an independent monitor checks the fabric side.
module tb_switch_port_rx;

  localparam int         PORT  = 1;
  localparam int         DEPTH = 4;
  localparam int         CNT_W = 8;
  localparam logic [3:0] OWN   = 4'b0010;

  logic             clk = 1'b0;
  logic             rst;
  logic             ip_valid;
  logic [15:0]      ip_data;
  logic             ip_suspend;
  logic             fwd_valid;
  logic [15:0]      fwd_data;
  logic [3:0]       fwd_dest;
  logic [1:0]       fwd_type;
  logic             fwd_ready;
  logic [CNT_W-1:0] drop_cnt;
  logic [15:0]      rx_pkt_cnt;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dest;
    logic [1:0]  ty;
  } exp_t;

  exp_t q[$];
  int   total    = 0;
  int   passed   = 0;
  int   acc_cnt  = 0;
  int   pop_cnt  = 0;
  int   exp_drop = 0;
  int   exp_rx   = 0;

  switch_port_rx #(
    .PORT_ID    (PORT),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ip_valid   (ip_valid),
    .ip_data    (ip_data),
    .ip_suspend (ip_suspend),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data),
    .fwd_dest   (fwd_dest),
    .fwd_type   (fwd_type),
    .fwd_ready  (fwd_ready),
    .drop_cnt   (drop_cnt),
    .rx_pkt_cnt (rx_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: drop rules and type from popcount of the target nibble.
  function automatic void model(input logic [15:0] w, output bit ok, output exp_t e);
    logic [3:0] tgt;
    logic [3:0] src;
    int         n;
    tgt    = w[3:0];
    src    = w[7:4];
    n      = $countones(tgt);
    e.data = w;
    e.dest = tgt & ~OWN;
    e.ty   = (n == 1) ? 2'd0 : ((n == 4) ? 2'd2 : 2'd1);
    ok     = (tgt != 4'd0) && (src == OWN) && (e.dest != 4'd0);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [3:0] src;
    src = ($urandom_range(3) != 0) ? OWN : 4'($urandom_range(15));
    return {8'($urandom), src, 4'($urandom_range(15))};
  endfunction

  function automatic logic [15:0] good_word();
    return {8'($urandom), OWN, 4'($urandom_range(15)) | 4'b1000};
  endfunction

  task automatic step(input logic v, input logic [15:0] d, input logic rdy, output bit acc);
    bit   ok;
    exp_t e;
    @(posedge clk);
    #1;
    ip_valid  = v;
    ip_data   = d;
    fwd_ready = rdy;
    @(negedge clk);
    chk("ip_suspend", 32'(ip_suspend), 32'((acc_cnt - pop_cnt) == DEPTH));
    acc = v && !ip_suspend;
    if (acc) begin
      model(d, ok, e);
      if (ok) begin
        q.push_back(e);
        acc_cnt++;
        if (exp_rx < 65535) exp_rx++;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    while ((q.size() != 0 || fwd_valid) && n < 60) begin
      step(1'b0, 16'h0, 1'b1, a);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_ip_suspend", 32'(ip_suspend), 32'd0);
    chk("rst_fwd_data", 32'(fwd_data), 32'd0);
    chk("rst_fwd_dest", 32'(fwd_dest), 32'd0);
    chk("rst_fwd_type", 32'(fwd_type), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_rx_pkt_cnt", 32'(rx_pkt_cnt), 32'd0);
    ip_valid  = 1'b0;
    fwd_ready = 1'b0;
    q.delete();
    acc_cnt  = 0;
    pop_cnt  = 0;
    exp_drop = 0;
    exp_rx   = 0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: every presented head must match the oldest outstanding packet.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && fwd_valid) begin
        if (q.size() == 0) begin
          chk("fwd_valid_without_packet", 32'(fwd_valid), 32'd0);
        end else begin
          chk("fwd_data", 32'(fwd_data), 32'(q[0].data));
          chk("fwd_dest", 32'(fwd_dest), 32'(q[0].dest));
          chk("fwd_type", 32'(fwd_type), 32'(q[0].ty));
          if (fwd_ready) begin
            $display("fwd pkt data=%h dest=%h type=%0d", fwd_data, fwd_dest, fwd_type);
            void'(q.pop_front());
            pop_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         a;
    bit         have;
    int         nacc;
    logic [15:0] cur;
    rst       = 1'b1;
    ip_valid  = 1'b0;
    ip_data   = 16'h0;
    fwd_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("init_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("init_ip_suspend", 32'(ip_suspend), 32'd0);
    chk("init_fwd_data", 32'(fwd_data), 32'd0);
    chk("init_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("init_rx_pkt_cnt", 32'(rx_pkt_cnt), 32'd0);
    #20 rst = 1'b1;

    // Single packet: one-cycle latency, no combinational ip->fwd path.
    step(1'b1, 16'hA521, 1'b0, a);
    chk("lat_accept", 32'(a), 32'd1);
    step(1'b0, 16'h0, 1'b0, a);
    chk("lat_not_yet", 32'(fwd_valid), 32'd0);
    step(1'b0, 16'h0, 1'b0, a);
    chk("lat_valid", 32'(fwd_valid), 32'd1);
    chk("lat_dest", 32'(fwd_dest), 32'h1);
    chk("lat_type", 32'(fwd_type), 32'd0);
    step(1'b0, 16'h0, 1'b1, a);
    step(1'b0, 16'h0, 1'b0, a);
    chk("lat_popped", 32'(fwd_valid), 32'd0);

    // Broadcast and multicast classification.
    step(1'b1, 16'h332F, 1'b0, a);
    step(1'b1, 16'h3326, 1'b0, a);
    step(1'b0, 16'h0, 1'b0, a);
    chk("bcast_dest", 32'(fwd_dest), 32'hD);
    chk("bcast_type", 32'(fwd_type), 32'd2);
    drain();

    // Drops: target zero, wrong source, self only.
    step(1'b1, 16'h0020, 1'b1, a);
    step(1'b1, 16'h0011, 1'b1, a);
    step(1'b1, 16'h0022, 1'b1, a);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, a);
    chk("drop_cnt_three", 32'(drop_cnt), 32'd3);
    chk("drop_no_valid", 32'(fwd_valid), 32'd0);

    // Back-pressure: fifth packet held until a single pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {8'(8'h10 + i), OWN, 4'h5}, 1'b0, a);
      chk("bp_fill_accept", 32'(a), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h1425, 1'b0, a);
      chk("bp_held_while_full", 32'(a), 32'd0);
    end
    step(1'b1, 16'h1425, 1'b1, a);
    chk("bp_pop_cycle_no_accept", 32'(a), 32'd0);
    step(1'b1, 16'h1425, 1'b0, a);
    chk("bp_accept_after_pop", 32'(a), 32'd1);
    drain();

    // Full FIFO streaming: one pop and one accept per cycle.
    for (int i = 0; i < 4; i++) step(1'b1, good_word(), 1'b0, a);
    nacc = 0;
    have = 1'b0;
    cur  = 16'h0;
    for (int i = 0; i < 20; i++) begin
      if (!have) begin
        cur  = good_word();
        have = 1'b1;
      end
      step(1'b1, cur, 1'b1, a);
      if (a) begin
        nacc++;
        have = 1'b0;
      end
    end
    chk("stream_accepts", 32'(nacc), 32'd19);
    drain();

    // Reset with two entries buffered; nothing stale may emerge afterwards.
    step(1'b1, good_word(), 1'b0, a);
    step(1'b1, good_word(), 1'b0, a);
    step(1'b0, 16'h0, 1'b0, a);
    async_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, a);
    chk("no_stale_after_reset", 32'(fwd_valid), 32'd0);
    step(1'b1, 16'h7724, 1'b1, a);
    drain();

    // Randomized traffic against the reference model.
    have = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!have && $urandom_range(9) < 7) begin
        cur  = rand_word();
        have = 1'b1;
      end
      step(have, have ? cur : 16'h0, 1'($urandom_range(9) < 6), a);
      if (a) have = 1'b0;
    end
    drain();

    chk("final_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`ifdef SWITCH_RX_STATS_EN
    chk("final_rx_pkt_cnt", 32'(rx_pkt_cnt), 32'(exp_rx));
`else
    chk("final_rx_pkt_cnt", 32'(rx_pkt_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
